cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two writeback producers, ALU and LSU.
- Each producer has its own small FIFO; one entry per cycle is broadcast to the reorder buffer, the reservation stations and the load/store buffer.
- Round-robin arbitration, per-producer almost-full backpressure, and a full flush on misbranch.
- Sits between alu/lsu outputs and the existing update_signal_from_alu/lsu inputs of downstream blocks.

Parameters:
- FIFO_DEPTH, 4, entries per producer FIFO (power of two, 2..8).
- FIFO_PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- misbranch_flag  in  1  flush request from commit stage
- alu_valid  in  1  ALU result present this cycle
- alu_rob_id  in  5  ROB id (1..16; 0 = none)
- alu_result  in  32  ALU value
- alu_target_pc  in  32  computed branch/jump target
- alu_jump_result  in  1  precise taken flag
- alu_full  out  1  ALU FIFO almost full; producer must stall
- lsu_valid  in  1  LSU result present this cycle
- lsu_rob_id  in  5  ROB id
- lsu_result  in  32  load value
- lsu_full  out  1  LSU FIFO almost full
- cdb_alu_valid  out  1  broadcast slot carries ALU entry
- cdb_lsu_valid  out  1  broadcast slot carries LSU entry
- cdb_rob_id  out  5  broadcast ROB id
- cdb_value  out  32  broadcast value
- cdb_target_pc  out  32  ALU target (0 for LSU grants)
- cdb_jump_result  out  1  ALU taken flag (0 for LSU grants)
- overflow_err  out  1  sticky: push attempted into a full FIFO

Behaviour:
- Reset (rst high at a clk edge):
  - Both FIFOs are emptied.
  - All cdb_* outputs become 0 and overflow_err becomes 0.
  - The round-robin last-grant pointer becomes LSU, so ALU wins the first tie.
- rdy low: no state changes and inputs are ignored; outputs hold their values.
- Flush: when misbranch_flag is high at an edge with rdy high (rst has priority over flush):
  - Both FIFOs are emptied and cdb_alu_valid/cdb_lsu_valid are cleared.
  - Inputs presented in that cycle are dropped.
  - The last-grant pointer is kept.
- Enqueue:
  - alu_valid with alu_rob_id != 0 pushes {rob_id, result, target_pc, jump_result}.
  - lsu_valid with lsu_rob_id != 0 pushes {rob_id, result}.
  - A valid with rob_id 0 is discarded silently.
- Almost-full:
  - The combinational x_full output is high when the FIFO count >= FIFO_DEPTH-1.
  - This leaves one slot of slack for a producer that launched in the same cycle.
- Overflow:
  - A push into a FIFO holding FIFO_DEPTH entries, with no pop in the same cycle, is dropped and sets overflow_err.
  - Push and pop in the same cycle on a full FIFO is legal.
- Arbitration, once per rdy cycle on the FIFO heads before enqueue:
  - Only one non-empty: that FIFO is granted.
  - Both non-empty: the source not granted last is granted.
  - The granted head pops, and the last-grant pointer updates.
- Output is registered:
  - The granted entry appears on cdb_* the cycle after the grant decision.
  - Exactly one of cdb_alu_valid/cdb_lsu_valid is high for one cycle.
  - With no grant, both valids are 0 and the data fields keep their previous values.
- Latency: a push into an empty FIFO at edge N makes the head visible after N. With no contention it is granted at edge N+1, and valid is visible in the cycle after edge N+1 (2 edges).
- Ordering: each FIFO preserves order within its source; there is no ordering guarantee across sources.
- Pointer wrap: read/write pointers are FIFO_PTR_W bits and wrap modulo FIFO_DEPTH. The count is FIFO_PTR_W+1 bits.
- Simultaneous push and pop on the same FIFO: count is unchanged, and the entry pushed in that cycle is never granted in the same cycle.

Decomposition:
- constant.v gains CDB_ALU/CDB_LSU source encodings and CDB_FIFO_DEPTH. It reuses ROB_ID_TYPE, DATA_TYPE, ADDR_TYPE, ZERO_ROB and ZERO_WORD.
- One sub-module, cdb_fifo: a width-parameterised synchronous FIFO with push, pop, flush, head, count and almost_full.
- cdb_fifo is instantiated twice (ALU width 70, LSU width 37).
- The arbiter and output register live in cdb_arbiter.

Test Plan:
- After rst, single ALU push (rob_id 3, result 0x11, target 0x100, jump 1): cdb_alu_valid high exactly once, 2 edges later, with id 3 / value 0x11 / target 0x100 / jump 1.
- ALU and LSU push every cycle for 8 cycles (ids 1..8 ALU, 9..16 LSU): grants strictly alternate ALU, LSU, ALU, ...; per-source order is preserved; nothing is lost.
- Four LSU pushes with no pop window (held by a pending rdy-low episode): lsu_full rises at count 3, and a 5th push sets overflow_err; a subsequent rst clears it.
- Three ALU entries queued, then misbranch_flag for 1 cycle together with a new alu_valid: next cycle both cdb valids are 0, FIFOs are empty, and no stale id is ever broadcast.
- rdy low for 5 cycles with entries queued: cdb outputs frozen and inputs ignored; after rdy returns, broadcasts resume in the original order.
- alu_valid with rob_id 0: no broadcast, FIFO count unchanged.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg: shared CDB types, source encodings and entry layouts
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cdb_arbiter_pkg;

  localparam int CDB_FIFO_DEPTH = 4;
  localparam int CDB_FIFO_PTR_W = 2;

  typedef logic [4:0]  rob_id_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam rob_id_t ZERO_ROB  = '0;
  localparam data_t   ZERO_WORD = '0;

  typedef enum logic {
    CDB_ALU = 1'b0,
    CDB_LSU = 1'b1
  } cdb_src_e;

  typedef struct packed {
    rob_id_t rob_id;
    data_t   result;
    addr_t   target_pc;
    logic    jump_result;
  } alu_entry_t;

  typedef struct packed {
    rob_id_t rob_id;
    data_t   result;
  } lsu_entry_t;

  localparam int ALU_ENTRY_W = $bits(alu_entry_t);
  localparam int LSU_ENTRY_W = $bits(lsu_entry_t);

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
// ----------------------------------------------------------------------------
// cdb_fifo: width-parameterised synchronous FIFO with flush and almost-full
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PTR_W:0]   count_o,
  output logic             almost_full_o,
  output logic             overflow_o
);

  localparam logic [PTR_W:0]   C_DEPTH   = DEPTH;
  localparam logic [PTR_W:0]   C_AF_LVL  = DEPTH - 1;
  localparam logic [PTR_W:0]   C_CNT_ONE = 1;
  localparam logic [PTR_W-1:0] C_PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic w_full, w_do_pop, w_do_push;

  assign w_full    = (count_q == C_DEPTH);
  assign w_do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = push_i && (!w_full || w_do_pop);

  assign overflow_o    = push_i && w_full && !w_do_pop;
  assign almost_full_o = (count_q >= C_AF_LVL);
  assign head_o        = mem_q[rd_ptr_q];
  assign count_o       = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter: round-robin sharing of the common data bus between ALU and LSU
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int FIFO_PTR_W = CDB_FIFO_PTR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        misbranch_flag,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rob_id,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_target_pc,
  input  logic        alu_jump_result,
  output logic        alu_full,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rob_id,
  input  logic [31:0] lsu_result,
  output logic        lsu_full,
  output logic        cdb_alu_valid,
  output logic        cdb_lsu_valid,
  output logic [4:0]  cdb_rob_id,
  output logic [31:0] cdb_value,
  output logic [31:0] cdb_target_pc,
  output logic        cdb_jump_result,
  output logic        overflow_err
);

  logic w_adv, w_flush;
  logic w_alu_push, w_lsu_push, w_gnt_alu, w_gnt_lsu;
  logic w_alu_ovf, w_lsu_ovf;
  logic [FIFO_PTR_W:0] w_alu_count, w_lsu_count;
  alu_entry_t w_alu_in, w_alu_head;
  lsu_entry_t w_lsu_in, w_lsu_head;

  cdb_src_e last_q, last_d;
  logic     alu_v_q, alu_v_d, lsu_v_q, lsu_v_d;
  rob_id_t  rob_q, rob_d;
  data_t    val_q, val_d;
  addr_t    tpc_q, tpc_d;
  logic     jmp_q, jmp_d;
  logic     ovf_q, ovf_d;

  assign w_adv   = rdy && !misbranch_flag;
  assign w_flush = rdy && misbranch_flag;

  assign w_alu_push = w_adv && alu_valid && (alu_rob_id != ZERO_ROB);
  assign w_lsu_push = w_adv && lsu_valid && (lsu_rob_id != ZERO_ROB);

  assign w_alu_in = '{rob_id: alu_rob_id, result: alu_result,
                      target_pc: alu_target_pc, jump_result: alu_jump_result};
  assign w_lsu_in = '{rob_id: lsu_rob_id, result: lsu_result};

  cdb_fifo #(.WIDTH(ALU_ENTRY_W), .DEPTH(FIFO_DEPTH), .PTR_W(FIFO_PTR_W)) u_alu_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (w_flush),
    .push_i       (w_alu_push),
    .data_i       (w_alu_in),
    .pop_i        (w_gnt_alu),
    .head_o       (w_alu_head),
    .count_o      (w_alu_count),
    .almost_full_o(alu_full),
    .overflow_o   (w_alu_ovf)
  );

  cdb_fifo #(.WIDTH(LSU_ENTRY_W), .DEPTH(FIFO_DEPTH), .PTR_W(FIFO_PTR_W)) u_lsu_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (w_flush),
    .push_i       (w_lsu_push),
    .data_i       (w_lsu_in),
    .pop_i        (w_gnt_lsu),
    .head_o       (w_lsu_head),
    .count_o      (w_lsu_count),
    .almost_full_o(lsu_full),
    .overflow_o   (w_lsu_ovf)
  );

  // Grant looks at occupancy before this cycle's push, so a fresh entry waits a cycle
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (w_adv) begin
      if ((w_alu_count != '0) && ((w_lsu_count == '0) || (last_q == CDB_LSU)))
        w_gnt_alu = 1'b1;
      else if (w_lsu_count != '0)
        w_gnt_lsu = 1'b1;
    end
  end

  always_comb begin
    last_d  = last_q;
    alu_v_d = 1'b0;
    lsu_v_d = 1'b0;
    rob_d   = rob_q;
    val_d   = val_q;
    tpc_d   = tpc_q;
    jmp_d   = jmp_q;
    ovf_d   = ovf_q | w_alu_ovf | w_lsu_ovf;
    if (w_gnt_alu) begin
      last_d  = CDB_ALU;
      alu_v_d = 1'b1;
      rob_d   = w_alu_head.rob_id;
      val_d   = w_alu_head.result;
      tpc_d   = w_alu_head.target_pc;
      jmp_d   = w_alu_head.jump_result;
    end else if (w_gnt_lsu) begin
      last_d  = CDB_LSU;
      lsu_v_d = 1'b1;
      rob_d   = w_lsu_head.rob_id;
      val_d   = w_lsu_head.result;
      tpc_d   = ZERO_WORD;
      jmp_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= CDB_LSU;
      alu_v_q <= 1'b0;
      lsu_v_q <= 1'b0;
      rob_q   <= ZERO_ROB;
      val_q   <= ZERO_WORD;
      tpc_q   <= ZERO_WORD;
      jmp_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (rdy) begin
      last_q  <= last_d;
      alu_v_q <= alu_v_d;
      lsu_v_q <= lsu_v_d;
      rob_q   <= rob_d;
      val_q   <= val_d;
      tpc_q   <= tpc_d;
      jmp_q   <= jmp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cdb_alu_valid   = alu_v_q;
  assign cdb_lsu_valid   = lsu_v_q;
  assign cdb_rob_id      = rob_q;
  assign cdb_value       = val_q;
  assign cdb_target_pc   = tpc_q;
  assign cdb_jump_result = jmp_q;
  assign overflow_err    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter: directed and random stimulus against a queue-based model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, misbranch_flag = 1'b0;
  logic        alu_valid = 1'b0, alu_jump_result = 1'b0;
  logic [4:0]  alu_rob_id = '0;
  logic [31:0] alu_result = '0, alu_target_pc = '0;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rob_id = '0;
  logic [31:0] lsu_result = '0;
  logic        alu_full, lsu_full, cdb_alu_valid, cdb_lsu_valid;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_value, cdb_target_pc;
  logic        cdb_jump_result, overflow_err;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_result(alu_result),
    .alu_target_pc(alu_target_pc), .alu_jump_result(alu_jump_result),
    .alu_full(alu_full),
    .lsu_valid(lsu_valid), .lsu_rob_id(lsu_rob_id), .lsu_result(lsu_result),
    .lsu_full(lsu_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsu_valid(cdb_lsu_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_target_pc(cdb_target_pc), .cdb_jump_result(cdb_jump_result),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] v;
    logic [31:0] t;
    logic        j;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  bit          m_last_alu;
  bit          m_ovf;
  bit          e_av, e_lv, e_j;
  logic [4:0]  e_id;
  logic [31:0] e_val, e_tpc;

  int n_cmp = 0;
  int n_err = 0;
  int g_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: two bounded queues, alternate on contention
  task automatic model(input bit r, input bit rd, input bit mb,
                       input bit av, input logic [4:0] aid, input logic [31:0] ares,
                       input logic [31:0] atpc, input bit aj,
                       input bit lv, input logic [4:0] lid, input logic [31:0] lres);
    ent_t e;
    int   g;
    if (r) begin
      aq.delete(); lq.delete();
      e_av = 0; e_lv = 0; e_id = '0; e_val = '0; e_tpc = '0; e_j = 0;
      m_last_alu = 0; m_ovf = 0;
    end else if (rd) begin
      if (mb) begin
        aq.delete(); lq.delete();
        e_av = 0; e_lv = 0;
      end else begin
        g = 0;
        if (aq.size() > 0 && lq.size() > 0) g = m_last_alu ? 2 : 1;
        else if (aq.size() > 0)             g = 1;
        else if (lq.size() > 0)             g = 2;
        e_av = (g == 1);
        e_lv = (g == 2);
        if (g == 1) begin
          e = aq.pop_front();
          e_id = e.id; e_val = e.v; e_tpc = e.t; e_j = e.j;
          m_last_alu = 1;
        end else if (g == 2) begin
          e = lq.pop_front();
          e_id = e.id; e_val = e.v; e_tpc = '0; e_j = 0;
          m_last_alu = 0;
        end
        if (av && aid != 0) begin
          if (aq.size() < DEPTH) aq.push_back('{id: aid, v: ares, t: atpc, j: aj});
          else m_ovf = 1;
        end
        if (lv && lid != 0) begin
          if (lq.size() < DEPTH) lq.push_back('{id: lid, v: lres, t: '0, j: 1'b0});
          else m_ovf = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit mb,
                      input bit av, input logic [4:0] aid, input logic [31:0] ares,
                      input logic [31:0] atpc, input bit aj,
                      input bit lv, input logic [4:0] lid, input logic [31:0] lres);
    rst = r; rdy = rd; misbranch_flag = mb;
    alu_valid = av; alu_rob_id = aid; alu_result = ares;
    alu_target_pc = atpc; alu_jump_result = aj;
    lsu_valid = lv; lsu_rob_id = lid; lsu_result = lres;
    model(r, rd, mb, av, aid, ares, atpc, aj, lv, lid, lres);
    @(posedge clk);
    #1;
    g_seen += int'(cdb_alu_valid) + int'(cdb_lsu_valid);
    check("alu_valid", cdb_alu_valid, e_av);
    check("lsu_valid", cdb_lsu_valid, e_lv);
    check("rob_id", cdb_rob_id, e_id);
    check("value", cdb_value, e_val);
    check("target_pc", cdb_target_pc, e_tpc);
    check("jump", cdb_jump_result, e_j);
    check("alu_full", alu_full, aq.size() >= DEPTH - 1);
    check("lsu_full", lsu_full, lq.size() >= DEPTH - 1);
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int na, nl, guard;
    bit av, lv;

    // Reset state
    do_reset();
    idle(1);

    // Single ALU push: broadcast two edges later, exactly once
    step(0, 1, 0, 1, 5'd3, 32'h11, 32'h100, 1, 0, 0, 0);
    check("t1_early", cdb_alu_valid, 1'b0);
    idle(1);
    check("t1_valid", cdb_alu_valid, 1'b1);
    check("t1_id", cdb_rob_id, 5'd3);
    check("t1_target", cdb_target_pc, 32'h100);
    idle(1);
    check("t1_once", cdb_alu_valid, 1'b0);

    // Both producers push 8 entries each, honouring backpressure
    do_reset();
    g_seen = 0;
    na = 0; nl = 0; guard = 0;
    while ((na < 8 || nl < 8) && guard < 100) begin
      av = (na < 8) && !alu_full;
      lv = (nl < 8) && !lsu_full;
      step(0, 1, 0, av, 5'(na + 1), $urandom, $urandom, 1'($urandom), lv, 5'(nl + 9), $urandom);
      if (av) na++;
      if (lv) nl++;
      guard++;
    end
    check("t2_guard", guard < 100, 1'b1);
    idle(12);
    check("t2_grants", g_seen, 16);

    // Flood ignoring full: LSU/ALU overflow, then reset clears it
    do_reset();
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 1, 5'(i + 1), $urandom, $urandom, 0, 1, 5'(i + 5), $urandom);
    check("t3_ovf_set", overflow_err, 1'b1);
    do_reset();
    check("t3_ovf_clr", overflow_err, 1'b0);

    // Queue ALU entries, then misbranch together with a new push
    step(0, 1, 0, 1, 5'd1, 32'hA1, 32'h10, 0, 1, 5'd9, 32'hB1);
    step(0, 1, 0, 1, 5'd2, 32'hA2, 32'h20, 1, 1, 5'd10, 32'hB2);
    step(0, 1, 0, 1, 5'd4, 32'hA4, 32'h40, 0, 0, 0, 0);
    step(0, 1, 1, 1, 5'd7, 32'hA7, 32'h70, 1, 1, 5'd11, 32'hB7);
    check("t4_alu_v", cdb_alu_valid, 1'b0);
    check("t4_lsu_v", cdb_lsu_valid, 1'b0);
    idle(4);
    check("t4_drained", g_seen, 0 + g_seen);

    // rdy low for 5 cycles with entries queued
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 1, 5'(i + 1), $urandom, $urandom, 1, 1, 5'(i + 12), $urandom);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1'($urandom), 1, 5'(i + 6), $urandom, $urandom, 0, 1, 5'(i + 2), $urandom);
    idle(10);

    // rob_id 0 is discarded
    step(0, 1, 0, 1, 5'd0, 32'hDEAD, 32'hBEEF, 1, 1, 5'd0, 32'hCAFE);
    idle(2);
    check("t6_none", cdb_alu_valid | cdb_lsu_valid, 1'b0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit r, rd, mb;
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 9) != 0);
      mb = ($urandom_range(0, 39) == 0);
      av = ($urandom_range(0, 9) < 6) && (!alu_full || $urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 9) < 6) && (!lsu_full || $urandom_range(0, 9) == 0);
      step(r, rd, mb, av, 5'($urandom_range(0, 16)), $urandom, $urandom, 1'($urandom),
           lv, 5'($urandom_range(0, 16)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
